// File: rtl/gtech_skid_reg.sv
// Two-entry skid register: MAIN drives Q directly, SKID absorbs one word when downstream stalls.
// Optional QN (~Q) output when GTECH_SKID_QN_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no word held, Q_VALID=0, D_READY=1
// ST_BUSY  | MAIN holds one word, Q_VALID=1, D_READY=1
// ST_FULL  | MAIN and SKID both hold words, D_READY=0
module gtech_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY
`ifdef GTECH_SKID_QN_EN
  ,
  output logic [WIDTH-1:0] QN
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             q_valid_r;
  logic             ready_r;

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      state     <= ST_EMPTY;
      main_r    <= '0;
      skid_r    <= '0;
      q_valid_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (D_VALID) begin
            main_r    <= D;
            state     <= ST_BUSY;
            q_valid_r <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (D_VALID && Q_READY) begin
            main_r <= D;
          end else if (D_VALID) begin
            skid_r  <= D;
            state   <= ST_FULL;
            ready_r <= 1'b0;
          end else if (Q_READY) begin
            // MAIN keeps its stale word; Q is ignored while Q_VALID is low
            state     <= ST_EMPTY;
            q_valid_r <= 1'b0;
          end
        end
        ST_FULL: begin
          if (Q_READY) begin
            main_r  <= skid_r;
            state   <= ST_BUSY;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          q_valid_r <= 1'b0;
          ready_r   <= 1'b1;
        end
      endcase
    end
  end

  // CLR gates ready directly so it drops and recovers without waiting for an edge
  assign D_READY = ready_r & ~CLR;
  assign Q       = main_r;
  assign Q_VALID = q_valid_r;

`ifdef GTECH_SKID_QN_EN
  assign QN = ~main_r;
`endif

endmodule

// File: tb/tb_gtech_skid_reg.sv
// Bench for gtech_skid_reg: directed cases then random valid/ready traffic against a
// two-word FIFO model (ready = fewer than two words held, valid = any word held).
module tb_gtech_skid_reg;

  localparam int W = 8;

  logic         CP = 1'b0;
  logic         CLR;
  logic [W-1:0] D;
  logic         D_VALID;
  logic         D_READY;
  logic [W-1:0] Q;
  logic         Q_VALID;
  logic         Q_READY;
`ifdef GTECH_SKID_QN_EN
  logic [W-1:0] QN;
`endif

  gtech_skid_reg #(.WIDTH(W)) dut (
    .CP      (CP),
    .CLR     (CLR),
    .D       (D),
    .D_VALID (D_VALID),
    .D_READY (D_READY),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_READY (Q_READY)
`ifdef GTECH_SKID_QN_EN
    ,
    .QN      (QN)
`endif
  );

  always #5 CP = ~CP;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] mq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 64'(Q_VALID), 64'(mq.size() > 0));
    chk({tag, "_ready"}, 64'(D_READY), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk({tag, "_q"}, 64'(Q), 64'(mq[0]));
`ifdef GTECH_SKID_QN_EN
      chk({tag, "_qn"}, 64'(QN), 64'(W'(~mq[0])));
`endif
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] d, input logic dv, input logic qr);
    logic in_x, out_x;
    D       = d;
    D_VALID = dv;
    Q_READY = qr;
    in_x    = dv && (mq.size() < 2);
    out_x   = qr && (mq.size() > 0);
    @(posedge CP);
    #1;
    if (out_x) void'(mq.pop_front());
    if (in_x) mq.push_back(d);
    chk_model(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, 64'(Q), 64'h0);
    chk({tag, "_valid"}, 64'(Q_VALID), 64'h0);
    chk({tag, "_ready"}, 64'(D_READY), 64'h0);
`ifdef GTECH_SKID_QN_EN
    chk({tag, "_qn"}, 64'(QN), 64'hFF);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1'b1; D = '0; D_VALID = 1'b0; Q_READY = 1'b0;
    #2;
    chk_reset("por");
    @(posedge CP); #1;
    CLR = 1'b0;
    #1;
    chk("por_release_ready", 64'(D_READY), 64'h1);

    // single word
    step("single_in", 8'hA5, 1'b1, 1'b0);
    chk("single_q", 64'(Q), 64'hA5);
    step("single_out", 8'h00, 1'b0, 1'b1);
    chk("single_empty", 64'(Q_VALID), 64'h0);

    // stall then drain
    step("stall1", 8'h11, 1'b1, 1'b0);
    step("stall2", 8'h22, 1'b1, 1'b0);
    chk("stall_full_ready", 64'(D_READY), 64'h0);
    step("stall3", 8'h33, 1'b1, 1'b0);
    chk("stall_q_stable", 64'(Q), 64'h11);
    step("drain1", 8'h44, 1'b0, 1'b1);
    chk("drain1_q", 64'(Q), 64'h22);
    step("drain2", 8'h55, 1'b0, 1'b1);
    chk("drain2_valid", 64'(Q_VALID), 64'h0);

    // reset while FULL; an edge under CLR must not transfer
    step("prefill1", 8'h66, 1'b1, 1'b0);
    step("prefill2", 8'h77, 1'b1, 1'b0);
    chk("prefill_full", 64'(D_READY), 64'h0);
    CLR = 1'b1;
    #1;
    chk_reset("clr_full");
    mq.delete();
    D = 8'h99; D_VALID = 1'b1; Q_READY = 1'b1;
    @(posedge CP); #1;
    chk_reset("clr_edge");
    CLR = 1'b0;
    #1;
    chk("clr_release_ready", 64'(D_READY), 64'h1);
    step("first_after_clr", 8'h5A, 1'b1, 1'b0);
    chk("first_after_clr_q", 64'(Q), 64'h5A);
    step("first_after_clr_out", 8'h00, 1'b0, 1'b1);

    // streaming: one word per cycle
    for (int i = 0; i < 256; i++) begin
      step("stream", W'(i), 1'b1, 1'b1);
      chk("stream_q", 64'(Q), 64'(i));
    end
    step("stream_tail", 8'h00, 1'b0, 1'b1);
    chk("stream_done", 64'(Q_VALID), 64'h0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      step("rand", W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gtech_skid_reg.md
GTECH_SKID_REG -- requirements
Module: gtech_skid_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width in bits (legal range 1..64).
REQ-002 SHALL provide port CP  input  1  clock, all state updates on rising edge.
REQ-003 SHALL provide port CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port D  input  WIDTH  upstream data.
REQ-005 SHALL provide port D_VALID  input  1  upstream data valid.
REQ-006 SHALL provide port D_READY  output  1  block can accept D this cycle.
REQ-007 SHALL provide port Q  output  WIDTH  registered data to downstream flop bank.
REQ-008 SHALL provide port Q_VALID  output  1  Q holds valid data.
REQ-009 SHALL provide port Q_READY  input  1  downstream accepts Q this cycle.
REQ-010 SHALL provide port QN  output  WIDTH  bitwise complement of Q; present only when GTECH_SKID_QN_EN is defined.
REQ-011 The interface SHALL use one clock, CP, and an asynchronous, active-high reset, CLR.

Function
REQ-012 An input transfer SHALL occur on a CP rising edge with D_VALID=1, D_READY=1 and CLR=0.
REQ-013 An output transfer SHALL occur on a CP rising edge with Q_VALID=1, Q_READY=1 and CLR=0.
REQ-014 The block SHALL hold two registers, MAIN (drives Q) and SKID, and a 3-state FSM: EMPTY, BUSY, FULL.
REQ-015 EMPTY: Q_VALID=0, D_READY=1; on input transfer, MAIN<=D and go to BUSY.
REQ-016 BUSY: Q_VALID=1, D_READY=1; input and output transfer: MAIN<=D, stay BUSY.
REQ-017 BUSY: input only (Q_READY=0): SKID<=D, MAIN unchanged, go to FULL.
REQ-018 BUSY: output only: go to EMPTY; MAIN keeps its old value, but Q is don't-care while Q_VALID=0.
REQ-019 FULL: Q_VALID=1, D_READY=0; on output transfer, MAIN<=SKID and go to BUSY; D is ignored.
REQ-020 D_READY and Q_VALID SHALL be decoded from state registers only, with no combinational path from D_VALID or Q_READY.
REQ-021 Q SHALL be a direct MAIN register output; latency from input transfer to Q_VALID is 1 cycle when EMPTY.
REQ-022 Q SHALL remain stable while Q_VALID=1 and Q_READY=0.
REQ-023 Data SHALL leave in acceptance order; no word is lost or duplicated.
REQ-024 Sustained D_VALID=1 and Q_READY=1 SHALL give one transfer per cycle (full throughput).
REQ-025 D_VALID or Q_READY toggling while idle SHALL NOT change Q or state unless a transfer occurs.

Reset
REQ-026 While CLR=1: state=EMPTY, MAIN=0, SKID=0, Q=0, Q_VALID=0, asynchronously.
REQ-027 D_READY SHALL be forced 0 asynchronously while CLR=1 and SHALL become 1 combinationally upon CLR deassertion.
REQ-028 CLR asserted in BUSY or FULL SHALL discard held data; no transfer completes on an edge where CLR=1.
REQ-029 First transfer after reset SHALL be possible on the first CP rising edge with CLR=0.

Configuration
REQ-030 Macro GTECH_SKID_QN_EN defined: QN port SHALL exist and equal ~Q at all times, including reset (QN=all ones).
REQ-031 Macro GTECH_SKID_QN_EN undefined: QN port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset: assert CLR mid-FULL (WIDTH=8) -> Q=8'h00, Q_VALID=0, D_READY=0 immediately; D_READY=1 after release.
REQ-033 Single word: EMPTY, D=8'hA5 with D_VALID=1 for one edge -> next cycle Q=8'hA5, Q_VALID=1; Q_READY=1 one edge -> Q_VALID=0.
REQ-034 Stall: send 8'h11, 8'h22 with Q_READY=0 -> FULL, D_READY=0, Q=8'h11 stable; a third word 8'h33 offered is not accepted.
REQ-035 Drain: from REQ-034 state, Q_READY=1 for 2 edges -> Q shows 8'h11 then 8'h22, then Q_VALID=0; order preserved.
REQ-036 Streaming: 256 words 0..255 with D_VALID=Q_READY=1 -> one word per cycle, sequence 0..255 in order.
REQ-037 Random valid/ready, 10k cycles, with GTECH_SKID_QN_EN defined -> scoreboard match, QN==~Q every cycle.
